// File: rtl/de_pipe_reg_if.sv
// D/E pipeline register bundle: D-stage inputs, E-stage outputs, and the
// W-stage write port that exists only when DE_PIPE_REG_WFWD_EN is defined.
interface de_pipe_reg_if #(
   parameter int unsigned TNEW_W = 2
);
   logic              stall;
   logic              flush;
   logic [31:0]       IR_D;
   logic [31:0]       PC_D;
   logic [31:0]       RD1_D;
   logic [31:0]       RD2_D;
   logic [31:0]       EXT_D;
   logic [4:0]        A3_D;
   logic [TNEW_W-1:0] Tnew_D;
`ifdef DE_PIPE_REG_WFWD_EN
   logic              WE_W;
   logic [4:0]        WA3_W;
   logic [31:0]       WD_W;
`endif
   logic [31:0]       IR_E;
   logic [31:0]       PC_E;
   logic [31:0]       PC8_E;
   logic [31:0]       RD1_E;
   logic [31:0]       RD2_E;
   logic [31:0]       EXT_E;
   logic [4:0]        A3_E;
   logic [TNEW_W-1:0] Tnew_E;
   logic              valid_E;

   modport master (
`ifdef DE_PIPE_REG_WFWD_EN
      output WE_W, WA3_W, WD_W,
`endif
      output stall, flush, IR_D, PC_D, RD1_D, RD2_D, EXT_D, A3_D, Tnew_D,
      input  IR_E, PC_E, PC8_E, RD1_E, RD2_E, EXT_E, A3_E, Tnew_E, valid_E
   );

   modport slave (
`ifdef DE_PIPE_REG_WFWD_EN
      input  WE_W, WA3_W, WD_W,
`endif
      input  stall, flush, IR_D, PC_D, RD1_D, RD2_D, EXT_D, A3_D, Tnew_D,
      output IR_E, PC_E, PC8_E, RD1_E, RD2_E, EXT_E, A3_E, Tnew_E, valid_E
   );
endinterface

// File: rtl/de_pipe_reg.sv
// D/E pipeline register: captures decoded D-stage state, inserts bubbles on stall/flush.
// Optional W-stage bypass into RD1/RD2 at capture is enabled by DE_PIPE_REG_WFWD_EN.
module de_pipe_reg #(
   parameter logic [31:0] NOP_IR = 32'h0000_0000,
   parameter int unsigned TNEW_W = 2
) (
   input logic          clk,
   input logic          reset,
   de_pipe_reg_if.slave bus
);
   logic              w_bubble;
   logic [31:0]       w_rd1;
   logic [31:0]       w_rd2;
   logic [TNEW_W-1:0] w_tnew;

   logic [31:0]       r_ir;
   logic [31:0]       r_pc;
   logic [31:0]       r_rd1;
   logic [31:0]       r_rd2;
   logic [31:0]       r_ext;
   logic [4:0]        r_a3;
   logic [TNEW_W-1:0] r_tnew;
   logic              r_valid;

   always_comb begin
      w_bubble = bus.stall | bus.flush;
      w_rd1    = bus.RD1_D;
      w_rd2    = bus.RD2_D;
`ifdef DE_PIPE_REG_WFWD_EN
      if (bus.WE_W && (bus.WA3_W != 5'd0)) begin
         if (bus.WA3_W == bus.IR_D[25:21]) w_rd1 = bus.WD_W;
         if (bus.WA3_W == bus.IR_D[20:16]) w_rd2 = bus.WD_W;
      end
`endif
      // $0 destinations never become forwarding sources
      if ((bus.A3_D == 5'd0) || (bus.Tnew_D == '0)) w_tnew = '0;
      else                                          w_tnew = bus.Tnew_D - TNEW_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ir    <= NOP_IR;
         r_pc    <= '0;
         r_rd1   <= '0;
         r_rd2   <= '0;
         r_ext   <= '0;
         r_a3    <= '0;
         r_tnew  <= '0;
         r_valid <= 1'b0;
      end else if (w_bubble) begin
         // PC kept only so trace tools can see where the bubble came from
         r_ir    <= NOP_IR;
         r_pc    <= bus.PC_D;
         r_rd1   <= '0;
         r_rd2   <= '0;
         r_ext   <= '0;
         r_a3    <= '0;
         r_tnew  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_ir    <= bus.IR_D;
         r_pc    <= bus.PC_D;
         r_rd1   <= w_rd1;
         r_rd2   <= w_rd2;
         r_ext   <= bus.EXT_D;
         r_a3    <= bus.A3_D;
         r_tnew  <= w_tnew;
         r_valid <= 1'b1;
      end
   end

   assign bus.IR_E    = r_ir;
   assign bus.PC_E    = r_pc;
   assign bus.PC8_E   = r_pc + 32'd8;
   assign bus.RD1_E   = r_rd1;
   assign bus.RD2_E   = r_rd2;
   assign bus.EXT_E   = r_ext;
   assign bus.A3_E    = r_a3;
   assign bus.Tnew_E  = r_tnew;
   assign bus.valid_E = r_valid;
endmodule

// File: tb/tb_de_pipe_reg.sv
// Self-checking bench for de_pipe_reg: directed scenarios plus a randomized run
// against a behavioural model. Define DE_PIPE_REG_WFWD_EN to cover the W bypass.
module tb_de_pipe_reg;
   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] ext;
      logic [4:0]  a3;
      logic [1:0]  tnew;
      logic        valid;
   } e_t;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   e_t   exp_q;

   de_pipe_reg_if #(.TNEW_W(2)) bus ();

   de_pipe_reg #(.NOP_IR(NOP), .TNEW_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // What E should hold after the next edge, derived from the rules directly
   function automatic e_t model_next();
      e_t n;
      int t;
      n = '0;
      n.ir = NOP;
      if (!reset) return n;
      if (bus.stall || bus.flush) begin
         n.pc = bus.PC_D;
         return n;
      end
      n.ir    = bus.IR_D;
      n.pc    = bus.PC_D;
      n.rd1   = bus.RD1_D;
      n.rd2   = bus.RD2_D;
`ifdef DE_PIPE_REG_WFWD_EN
      if (bus.WE_W && bus.WA3_W != 0 && bus.WA3_W == bus.IR_D[25:21]) n.rd1 = bus.WD_W;
      if (bus.WE_W && bus.WA3_W != 0 && bus.WA3_W == bus.IR_D[20:16]) n.rd2 = bus.WD_W;
`endif
      n.ext   = bus.EXT_D;
      n.a3    = bus.A3_D;
      n.valid = 1'b1;
      t = int'(bus.Tnew_D);
      n.tnew = (bus.A3_D == 0 || t == 0) ? 2'd0 : 2'(t - 1);
      return n;
   endfunction

   task automatic tick();
      exp_q = model_next();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] rd1,
                        input logic [31:0] rd2, input logic [31:0] ext, input logic [4:0] a3,
                        input logic [1:0] tnew, input logic st, input logic fl);
      bus.IR_D   = ir;
      bus.PC_D   = pc;
      bus.RD1_D  = rd1;
      bus.RD2_D  = rd2;
      bus.EXT_D  = ext;
      bus.A3_D   = a3;
      bus.Tnew_D = tnew;
      bus.stall  = st;
      bus.flush  = fl;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(32'h3421_0005, 32'h3000, 32'h1, 32'h2, 32'h5, 5'd1, 2'd1, 1'b0, 1'b0);
      tick();
      tick();
      vectors++;
      if (bus.IR_E !== 32'h0) begin
         miscompares++; $display("FAIL reset_ir got %h expected %h", bus.IR_E, 32'h0);
      end
      vectors++;
      if (bus.A3_E !== 5'd0 || bus.Tnew_E !== 2'd0) begin
         miscompares++; $display("FAIL reset_a3_tnew got %0d/%0d expected 0/0", bus.A3_E, bus.Tnew_E);
      end
      vectors++;
      if (bus.valid_E !== 1'b0) begin
         miscompares++; $display("FAIL reset_valid got %b expected 0", bus.valid_E);
      end
      vectors++;
      if (bus.PC8_E !== 32'd8 || bus.RD1_E !== 32'd0) begin
         miscompares++; $display("FAIL reset_pc8_rd1 got %h/%h expected 8/0", bus.PC8_E, bus.RD1_E);
      end
   endtask

   task automatic test_capture();
      reset = 1'b1;
      drive(32'h3421_0005, 32'h3000, 32'h0000_0010, 32'h0, 32'h5, 5'd1, 2'd1, 1'b0, 1'b0);
      tick();
      vectors++;
      if (bus.IR_E !== 32'h3421_0005 || bus.PC8_E !== 32'h3008) begin
         miscompares++;
         $display("FAIL capture_ir_pc8 got %h/%h expected 34210005/00003008", bus.IR_E, bus.PC8_E);
      end
      vectors++;
      if (bus.Tnew_E !== 2'd0 || bus.valid_E !== 1'b1 || bus.A3_E !== 5'd1) begin
         miscompares++;
         $display("FAIL capture_ctl got tnew=%0d valid=%b a3=%0d expected 0/1/1",
                  bus.Tnew_E, bus.valid_E, bus.A3_E);
      end
      vectors++;
      if (bus.EXT_E !== 32'h5 || bus.RD1_E !== 32'h10) begin
         miscompares++; $display("FAIL capture_data got %h/%h expected 5/10", bus.EXT_E, bus.RD1_E);
      end
   endtask

   task automatic test_stall();
      // lw $2,0($1)
      drive(32'h8C22_0000, 32'h3004, 32'h100, 32'h0, 32'h0, 5'd2, 2'd2, 1'b0, 1'b0);
      tick();
      vectors++;
      if (bus.Tnew_E !== 2'd1) begin
         miscompares++; $display("FAIL stall_lw_tnew got %0d expected 1", bus.Tnew_E);
      end
      // addu $3,$1,$2 held in D for one stall cycle
      drive(32'h0022_1821, 32'h3008, 32'h100, 32'h55, 32'h0, 5'd3, 2'd1, 1'b1, 1'b0);
      tick();
      vectors++;
      if (bus.IR_E !== 32'h0 || bus.valid_E !== 1'b0 || bus.RD1_E !== 32'h0) begin
         miscompares++;
         $display("FAIL stall_bubble got ir=%h valid=%b rd1=%h expected 0/0/0",
                  bus.IR_E, bus.valid_E, bus.RD1_E);
      end
      vectors++;
      if (bus.PC_E !== 32'h3008) begin
         miscompares++; $display("FAIL stall_pc got %h expected 00003008", bus.PC_E);
      end
      bus.stall = 1'b0;
      tick();
      vectors++;
      if (bus.IR_E !== 32'h0022_1821 || bus.RD1_E !== 32'h100 || bus.RD2_E !== 32'h55 ||
          bus.valid_E !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_release got ir=%h rd1=%h rd2=%h valid=%b expected 00221821/100/55/1",
                  bus.IR_E, bus.RD1_E, bus.RD2_E, bus.valid_E);
      end
   endtask

   task automatic test_flush_stall_zero();
      drive(32'h0022_1821, 32'h300C, 32'h7, 32'h8, 32'h9, 5'd3, 2'd1, 1'b1, 1'b1);
      tick();
      vectors++;
      if (bus.IR_E !== 32'h0 || bus.valid_E !== 1'b0 || bus.A3_E !== 5'd0 ||
          bus.Tnew_E !== 2'd0 || bus.EXT_E !== 32'h0 || bus.RD2_E !== 32'h0) begin
         miscompares++;
         $display("FAIL flush_stall_bubble got ir=%h valid=%b a3=%0d tnew=%0d",
                  bus.IR_E, bus.valid_E, bus.A3_E, bus.Tnew_E);
      end
      drive(32'h8C20_0000, 32'h3010, 32'h7, 32'h8, 32'h0, 5'd0, 2'd2, 1'b0, 1'b0);
      tick();
      vectors++;
      if (bus.A3_E !== 5'd0 || bus.Tnew_E !== 2'd0 || bus.valid_E !== 1'b1) begin
         miscompares++;
         $display("FAIL zero_dest got a3=%0d tnew=%0d valid=%b expected 0/0/1",
                  bus.A3_E, bus.Tnew_E, bus.valid_E);
      end
   endtask

   task automatic test_sat_wrap();
      drive(32'h0000_0008, 32'hFFFF_FFF8, 32'h1, 32'h2, 32'h3, 5'd4, 2'd0, 1'b0, 1'b0);
      tick();
      vectors++;
      if (bus.Tnew_E !== 2'd0 || bus.A3_E !== 5'd4) begin
         miscompares++;
         $display("FAIL tnew_saturate got tnew=%0d a3=%0d expected 0/4", bus.Tnew_E, bus.A3_E);
      end
      vectors++;
      if (bus.PC8_E !== 32'h0 || bus.PC_E !== 32'hFFFF_FFF8) begin
         miscompares++;
         $display("FAIL pc8_wrap got pc=%h pc8=%h expected fffffff8/00000000", bus.PC_E, bus.PC8_E);
      end
   endtask

`ifdef DE_PIPE_REG_WFWD_EN
   task automatic test_wfwd();
      bus.WE_W  = 1'b1;
      bus.WA3_W = 5'd5;
      bus.WD_W  = 32'hDEAD_BEEF;
      // addu $3,$5,$6
      drive(32'h00A6_1821, 32'h3020, 32'h1111, 32'h2222, 32'h0, 5'd3, 2'd1, 1'b0, 1'b0);
      tick();
      vectors++;
      if (bus.RD1_E !== 32'hDEAD_BEEF || bus.RD2_E !== 32'h2222) begin
         miscompares++;
         $display("FAIL wfwd_rs got rd1=%h rd2=%h expected deadbeef/00002222", bus.RD1_E, bus.RD2_E);
      end
      bus.WA3_W = 5'd0;
      bus.IR_D  = 32'h0006_1821;
      tick();
      vectors++;
      if (bus.RD1_E !== 32'h1111) begin
         miscompares++; $display("FAIL wfwd_zero got rd1=%h expected 00001111", bus.RD1_E);
      end
      bus.WA3_W = 5'd6;
      bus.stall = 1'b1;
      tick();
      vectors++;
      if (bus.RD2_E !== 32'h0 || bus.valid_E !== 1'b0) begin
         miscompares++;
         $display("FAIL wfwd_bubble got rd2=%h valid=%b expected 0/0", bus.RD2_E, bus.valid_E);
      end
      bus.stall = 1'b0;
      bus.WE_W  = 1'b0;
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 19) != 0);
         drive($urandom, $urandom, $urandom, $urandom, $urandom,
               5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
`ifdef DE_PIPE_REG_WFWD_EN
         bus.WE_W  = ($urandom_range(0, 1) == 1);
         bus.WA3_W = 5'($urandom_range(0, 3));
         bus.WD_W  = $urandom;
         bus.IR_D[25:21] = 5'($urandom_range(0, 3));
         bus.IR_D[20:16] = 5'($urandom_range(0, 3));
`endif
         tick();
         vectors++;
         if ({bus.IR_E, bus.PC_E, bus.RD1_E, bus.RD2_E, bus.EXT_E, bus.A3_E, bus.Tnew_E,
              bus.valid_E} !== exp_q || bus.PC8_E !== exp_q.pc + 32'd8) begin
            miscompares++;
            $display("FAIL random_%0d got ir=%h pc=%h rd1=%h rd2=%h ext=%h a3=%0d tnew=%0d v=%b pc8=%h expected ir=%h pc=%h rd1=%h rd2=%h ext=%h a3=%0d tnew=%0d v=%b",
                     i, bus.IR_E, bus.PC_E, bus.RD1_E, bus.RD2_E, bus.EXT_E, bus.A3_E,
                     bus.Tnew_E, bus.valid_E, bus.PC8_E, exp_q.ir, exp_q.pc, exp_q.rd1,
                     exp_q.rd2, exp_q.ext, exp_q.a3, exp_q.tnew, exp_q.valid);
         end
      end
      reset = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      drive('0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
`ifdef DE_PIPE_REG_WFWD_EN
      bus.WE_W  = 1'b0;
      bus.WA3_W = 5'd0;
      bus.WD_W  = 32'h0;
`endif
      @(negedge clk);
      test_reset();
      test_capture();
      test_stall();
      test_flush_stall_zero();
      test_sat_wrap();
`ifdef DE_PIPE_REG_WFWD_EN
      test_wfwd();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/de_pipe_reg.md
Name: de_pipe_reg

Overview:
- D/E pipeline register of the five-stage MIPS core.
- Captures the decoded D-stage instruction and its operands each cycle and presents them to the E stage: E-stage controller (IR_E), ALU (RD1_E/RD2_E/EXT_E) and hazard unit (A3_E/Tnew_E).
- Owns bubble insertion on stall, and flush.
- Carries the Tnew countdown used by stall/forward logic.

Parameters:
- NOP_IR, 32'h0000_0000, instruction word injected as a bubble (sll $0,$0,0).
- TNEW_W, 2, width of the Tnew field.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- stall  in  1  hazard unit: D held upstream; insert bubble into E.
- flush  in  1  discard the D-stage instruction; insert bubble into E.
- IR_D  in  32  D-stage instruction word.
- PC_D  in  32  D-stage PC.
- RD1_D  in  32  GRF rs read data.
- RD2_D  in  32  GRF rt read data.
- EXT_D  in  32  extended immediate.
- A3_D  in  5  destination register (0 = no write).
- Tnew_D  in  TNEW_W  cycles from D until result available.
- IR_E  out  32  registered instruction.
- PC_E  out  32  registered PC.
- PC8_E  out  32  PC_E + 8 (jal link value).
- RD1_E  out  32  registered rs data.
- RD2_E  out  32  registered rt data.
- EXT_E  out  32  registered immediate.
- A3_E  out  5  registered destination.
- Tnew_E  out  TNEW_W  remaining cycles in E.
- valid_E  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (reset==0 at posedge): IR_E=NOP_IR; PC_E, RD1_E, RD2_E, EXT_E = 0; A3_E=0; Tnew_E=0; valid_E=0. PC8_E = 8 (combinational from PC_E).
- Reset wins over stall/flush/capture. Reset mid-stream drops the E instruction; no partial state survives.
- Normal capture (reset=1, stall=0, flush=0): one-cycle latency; all *_E take the *_D values. valid_E=1. Tnew_E = Tnew_D-1, saturating at 0 (Tnew_D=0 gives 0).
- A3 gating: if A3_D==0 then A3_E=0 and Tnew_E=0, so $0 never becomes a forwarding source.
- Bubble (stall=1 or flush=1, either or both):
  - IR_E=NOP_IR, A3_E=0, Tnew_E=0, valid_E=0.
  - RD1_E, RD2_E, EXT_E = 0.
  - PC_E = PC_D (kept for debug trace only).
- stall and flush both high: a single bubble; identical to either alone.
- Consecutive stalls: a bubble every cycle. The first cycle with stall low captures the (held) D instruction.
- PC8_E: combinational PC_E + 32'd8, modulo 2^32 (0xFFFF_FFF8 gives 0x0000_0000).
- No combinational path from any input to any output.

Optional Feature:
- Macro: DE_PIPE_REG_WFWD_EN.
- Enabled: adds inputs WE_W (1), WA3_W (5), WD_W (32) from the W stage.
  - At capture, if WE_W and WA3_W!=0 and WA3_W==IR_D[25:21], RD1_E takes WD_W instead of RD1_D.
  - Same rule for RD2 with IR_D[20:16].
  - Has no effect on a bubble.
- Disabled: ports absent. The GRF must be write-through.

Test Plan:
- Reset: hold reset=0 two cycles with IR_D=32'h3421_0005 -> IR_E=0, A3_E=0, valid_E=0, PC8_E=8.
- Capture: ori IR_D=32'h3421_0005, PC_D=0x3000, EXT_D=5, A3_D=1, Tnew_D=1 -> next cycle IR_E=0x34210005, PC8_E=0x3008, Tnew_E=0, valid_E=1.
- Stall: lw then dependent addu, stall=1 for one cycle -> E shows IR_E=0, valid_E=0; next cycle addu captured with unchanged operands.
- Flush and stall together, then $0 dest: stall=1 and flush=1 -> one bubble. A3_D=0 with Tnew_D=2 -> A3_E=0, Tnew_E=0.
- Saturation and wrap: Tnew_D=0 -> Tnew_E=0. PC_D=0xFFFF_FFF8 -> PC8_E=0.
- DE_PIPE_REG_WFWD_EN defined:
  - WE_W=1, WA3_W=5, WD_W=0xDEAD_BEEF, IR_D rs=5 -> RD1_E=0xDEADBEEF.
  - Same with WA3_W=0 -> RD1_E=RD1_D.
